// File: rtl/mem_map_pkg.sv
// Shared definitions for the CPU memory bus controller.
// Contents:
//   - the address map (start/end of each device window)
//   - the region, FSM state and bus-owner enums
//   - decode_region(): maps an address to the region that claims it
package mem_map_pkg;

   localparam logic [31:0] LEDS_START = 32'h5000_0000;
   localparam logic [31:0] LEDS_END   = 32'h5000_0FFF;
   localparam logic [31:0] SEG_START  = 32'h6000_0000;
   localparam logic [31:0] SEG_END    = 32'h6000_0FFF;
   localparam logic [31:0] BTN_START  = 32'h7000_0000;
   localparam logic [31:0] BTN_END    = 32'h7000_0FFF;
   localparam logic [31:0] RAM_START  = 32'h8000_0000;
   localparam logic [31:0] RAM_END    = 32'h9FFF_FFFF;

   typedef enum logic [2:0] {REG_NONE, REG_RAM, REG_LEDS, REG_SEG, REG_BTN} region_e;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef enum logic {FETCH, DATA} owner_e;

   function automatic region_e decode_region(input logic [31:0] addr);
      region_e r;
      r = REG_NONE;
      if      (addr >= LEDS_START && addr <= LEDS_END) r = REG_LEDS;
      else if (addr >= SEG_START  && addr <= SEG_END)  r = REG_SEG;
      else if (addr >= BTN_START  && addr <= BTN_END)  r = REG_BTN;
      else if (addr >= RAM_START  && addr <= RAM_END)  r = REG_RAM;
      return r;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Sequences CPU memory traffic (instruction fetch + data load/store) onto the
// shared RAM/MMIO bus, one transaction at a time.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   if_req/addr -> if_gnt/rvalid/err/rdata        fetch port
//   d_req/we/be/addr/wdata -> d_gnt/rvalid/err/rdata   data port
//   bus_addr/we/be/wdata_o        latched transaction, valid only in ACCESS
//   en_*_o                        one-hot device enables (zero outside ACCESS)
//   *_rdata_i                     device read data
module mem_bus_ctrl
   import mem_map_pkg::*;
#(
   parameter int RAM_LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic        if_err_o,
   output logic [31:0] if_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_be_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic        d_err_o,
   output logic [31:0] d_rdata_o,
   output logic [31:0] bus_addr_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   output logic        en_ram_o,
   output logic        en_leds_o,
   output logic        en_7_seg_lcd_o,
   output logic        en_buttons_o,
   input  logic [31:0] ram_rdata_i,
   input  logic [31:0] leds_rdata_i,
   input  logic [31:0] seg_rdata_i,
   input  logic [31:0] buttons_rdata_i
);

   localparam int CNT_W = $clog2(RAM_LATENCY + 1);

   state_e          state;
   owner_e          owner, last_owner;
   region_e         region_q;
   logic [31:0]     addr_q, wdata_q, rdata_q;
   logic            we_q, err_q;
   logic [3:0]      be_q;
   logic [CNT_W-1:0] cnt;

   // Grant decision; gated by reset so no grant pulse is shown on an edge
   // that will not latch anything.
   logic gnt_if, gnt_d;
   always_comb begin
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
      if (rst_ni && state == IDLE) begin
         if (if_req_i && d_req_i) begin
            // Contention: alternate away from whoever went last.
            if (last_owner == FETCH) gnt_d  = 1'b1;
            else                     gnt_if = 1'b1;
         end else begin
            gnt_if = if_req_i;
            gnt_d  = d_req_i;
         end
      end
   end

   logic [31:0] sel_addr;
   region_e     sel_region;
   logic        sel_fault;
   assign sel_addr   = gnt_d ? d_addr_i : if_addr_i;
   assign sel_region = decode_region(sel_addr);
   // Instructions may only come from RAM.
   assign sel_fault  = (sel_region == REG_NONE) || (gnt_if && sel_region != REG_RAM);

   logic access_last;
   assign access_last = (region_q != REG_RAM) || (cnt == CNT_W'(RAM_LATENCY - 1));

   logic [31:0] dev_rdata;
   always_comb begin
      case (region_q)
         REG_RAM:  dev_rdata = ram_rdata_i;
         REG_LEDS: dev_rdata = leds_rdata_i;
         REG_SEG:  dev_rdata = seg_rdata_i;
         REG_BTN:  dev_rdata = buttons_rdata_i;
         default:  dev_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= IDLE;
         owner      <= FETCH;
         last_owner <= FETCH;
         region_q   <= REG_NONE;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         we_q       <= 1'b0;
         be_q       <= 4'h0;
         err_q      <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_if || gnt_d) begin
                  owner    <= gnt_d ? DATA : FETCH;
                  addr_q   <= sel_addr;
                  we_q     <= gnt_d & d_we_i;
                  be_q     <= gnt_d ? d_be_i : 4'hF;
                  wdata_q  <= gnt_d ? d_wdata_i : 32'h0;
                  region_q <= sel_region;
                  err_q    <= sel_fault;
                  rdata_q  <= 32'h0;
                  cnt      <= '0;
                  state    <= sel_fault ? RESP : ACCESS;
               end
            end
            ACCESS: begin
               if (access_last) begin
                  rdata_q <= we_q ? 32'h0 : dev_rdata;
                  state   <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               last_owner <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic in_access, in_resp;
   assign in_access = (state == ACCESS);
   assign in_resp   = (state == RESP);

   assign if_gnt_o = gnt_if;
   assign d_gnt_o  = gnt_d;

   assign bus_addr_o  = in_access ? addr_q  : 32'h0;
   assign bus_we_o    = in_access & we_q;
   assign bus_be_o    = in_access ? be_q    : 4'h0;
   assign bus_wdata_o = in_access ? wdata_q : 32'h0;

   assign en_ram_o       = in_access && region_q == REG_RAM;
   assign en_leds_o      = in_access && region_q == REG_LEDS;
   assign en_7_seg_lcd_o = in_access && region_q == REG_SEG;
   assign en_buttons_o   = in_access && region_q == REG_BTN;

   assign if_rvalid_o = in_resp && owner == FETCH;
   assign d_rvalid_o  = in_resp && owner == DATA;
   assign if_err_o    = if_rvalid_o & err_q;
   assign d_err_o     = d_rvalid_o & err_q;
   assign if_rdata_o  = (if_rvalid_o && !err_q) ? rdata_q : 32'h0;
   assign d_rdata_o   = (d_rvalid_o && !err_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a transaction-level model checks every
// output on every cycle, and the directed tasks pin latencies and data with
// hand-computed literals.
module tb_mem_bus_ctrl;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [3:0]  d_be = 4'h0;
   logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
   logic [31:0] ram_rd = 32'h0000_0013, leds_rd = 32'h0000_00A5;
   logic [31:0] seg_rd = 32'h0000_003C, btn_rd = 32'h0000_0007;

   logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, bus_we;
   logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        en_ram, en_leds, en_seg, en_btn;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.RAM_LATENCY(L)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_err_o(if_err), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
      .d_err_o(d_err), .d_rdata_o(d_rdata),
      .bus_addr_o(bus_addr), .bus_we_o(bus_we), .bus_be_o(bus_be),
      .bus_wdata_o(bus_wdata),
      .en_ram_o(en_ram), .en_leds_o(en_leds), .en_7_seg_lcd_o(en_seg),
      .en_buttons_o(en_btn),
      .ram_rdata_i(ram_rd), .leds_rdata_i(leds_rd), .seg_rdata_i(seg_rd),
      .buttons_rdata_i(btn_rd)
   );

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // region codes: 0 none, 1 ram, 2 leds, 3 seg, 4 buttons
   function automatic int region_of(input logic [31:0] a);
      if (a >= 32'h5000_0000 && a <= 32'h5000_0FFF) return 2;
      if (a >= 32'h6000_0000 && a <= 32'h6000_0FFF) return 3;
      if (a >= 32'h7000_0000 && a <= 32'h7000_0FFF) return 4;
      if (a >= 32'h8000_0000 && a <= 32'h9FFF_FFFF) return 1;
      return 0;
   endfunction

   int          m_t = -1;     // cycles since grant, -1 when no transaction
   int          m_lat = 0;    // grant-to-response distance in cycles
   int          m_reg = 0;
   logic        m_own_d = 1'b0, m_last_d = 1'b0, m_we = 1'b0, m_err = 1'b0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
   logic [3:0]  m_be = 0;

   logic        e_if_gnt, e_d_gnt, acc, rsp;
   logic [3:0]  e_en;

   always @(negedge clk) begin
      e_if_gnt = 1'b0;
      e_d_gnt  = 1'b0;
      if (rst_ni && m_t < 0) begin
         if (if_req && d_req) begin
            if (m_last_d) e_if_gnt = 1'b1;
            else          e_d_gnt  = 1'b1;
         end else begin
            e_if_gnt = if_req;
            e_d_gnt  = d_req;
         end
      end
      acc  = (m_t >= 1 && m_t < m_lat);
      rsp  = (m_t >= 1 && m_t == m_lat);
      e_en = 4'h0;
      if (acc) e_en = 4'b1000 >> (m_reg - 1);   // {ram, leds, seg, btn}

      chk("if_gnt", if_gnt, e_if_gnt);
      chk("d_gnt", d_gnt, e_d_gnt);
      chk("enables", {en_ram, en_leds, en_seg, en_btn}, e_en);
      chk("bus_addr", bus_addr, acc ? m_addr : 32'h0);
      chk("bus_ctl", {bus_we, bus_be}, acc ? {m_we, m_be} : 5'h0);
      chk("bus_wdata", bus_wdata, acc ? m_wdata : 32'h0);
      chk("if_rvalid", if_rvalid, rsp && !m_own_d);
      chk("d_rvalid", d_rvalid, rsp && m_own_d);
      if (rsp && !m_own_d) chk("if_resp", {if_err, if_rdata}, {m_err, m_err ? 32'h0 : m_rdata});
      if (rsp && m_own_d)  chk("d_resp", {d_err, d_rdata}, {m_err, m_err ? 32'h0 : m_rdata});

      // the word returned is what the device presents on the final access cycle
      if (acc && m_t == m_lat - 1) begin
         case (m_reg)
            1: m_rdata = ram_rd;
            2: m_rdata = leds_rd;
            3: m_rdata = seg_rd;
            default: m_rdata = btn_rd;
         endcase
         if (m_we) m_rdata = 32'h0;
      end

      // advance across the coming edge
      if (!rst_ni) begin
         m_t = -1;
         m_last_d = 1'b0;
      end else if (rsp) begin
         m_last_d = m_own_d;
         m_t = -1;
      end else if (m_t >= 1) begin
         m_t++;
      end else if (e_if_gnt || e_d_gnt) begin
         m_own_d = e_d_gnt;
         m_addr  = e_d_gnt ? d_addr : if_addr;
         m_we    = e_d_gnt & d_we;
         m_be    = e_d_gnt ? d_be : 4'hF;
         m_wdata = e_d_gnt ? d_wdata : 32'h0;
         m_reg   = region_of(m_addr);
         m_err   = (m_reg == 0) || (!e_d_gnt && m_reg != 1);
         m_rdata = 32'h0;
         m_lat   = m_err ? 1 : (m_reg == 1 ? L + 1 : 2);
         m_t     = 1;
      end
   end

   // ---------------- directed stimulus ----------------
   // dp=1: data port, dp=0: fetch port
   task automatic run(input string nm, input logic dp, input logic [31:0] a,
                      input logic we, input logic [3:0] be, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_en, input logic [31:0] exp_bw);
      int n, en_n;
      logic ok;
      logic [31:0] bw, rd;
      logic er;
      @(posedge clk); #1;
      if (dp) begin d_req = 1; d_addr = a; d_we = we; d_be = be; d_wdata = wd; end
      else    begin if_req = 1; if_addr = a; end
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dp ? d_gnt : if_gnt) begin ok = 1; break; end
      end
      chk({nm, " gnt"}, ok, 1);
      @(posedge clk); #1;
      d_req = 0; if_req = 0;
      n = 0; en_n = 0; bw = 0; ok = 0; rd = 0; er = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (en_ram | en_leds | en_seg | en_btn) begin en_n++; bw = bus_wdata; end
         if (dp ? d_rvalid : if_rvalid) begin
            n = i; ok = 1;
            rd = dp ? d_rdata : if_rdata;
            er = dp ? d_err : if_err;
            break;
         end
      end
      chk({nm, " rvalid"}, ok, 1);
      chk({nm, " lat"}, n, exp_lat);
      chk({nm, " rdata"}, rd, exp_rd);
      chk({nm, " err"}, er, exp_err);
      chk({nm, " en_cycles"}, en_n, exp_en);
      if (exp_en > 0) chk({nm, " bus_wdata"}, bw, exp_bw);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vecs);
      $fatal(1);
   end

   int gq[$];
   int gcyc[$];

   initial begin
      int n, cyc, rv;
      logic ok;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, en_ram, en_leds, en_seg, en_btn, bus_we, bus_be}, 0);
      chk("reset bus_addr", bus_addr, 0);
      @(posedge clk); #1 rst_ni = 1;

      // 1. LEDS load and 2. RAM fetch
      run("leds load", 1, 32'h5000_0004, 0, 4'hF, 0, 2, 32'hA5, 0, 1, 0);
      run("ram fetch", 0, 32'h8000_0000, 0, 4'h0, 0, L + 1, 32'h13, 0, L, 0);
      // 4. faults and region edges
      run("none store", 1, 32'hA000_0000, 1, 4'hF, 32'h1234, 1, 0, 1, 0, 0);
      run("none load", 1, 32'h4FFF_FFFF, 0, 4'hF, 0, 1, 0, 1, 0, 0);
      run("leds edge", 1, 32'h5000_0FFF, 0, 4'hF, 0, 2, 32'hA5, 0, 1, 0);
      run("leds past", 1, 32'h5000_1000, 0, 4'hF, 0, 1, 0, 1, 0, 0);
      // 5. seg fetch faults, seg store succeeds
      run("seg fetch", 0, 32'h6000_0000, 0, 4'h0, 0, 1, 0, 1, 0, 0);
      run("seg store", 1, 32'h6000_0000, 1, 4'hF, 32'h3F, 2, 0, 0, 1, 32'h3F);
      run("btn load", 1, 32'h7000_0FFF, 0, 4'hF, 0, 2, 32'h7, 0, 1, 0);
      run("ram store be0", 1, 32'h8000_0010, 1, 4'h0, 32'hDEADBEEF, L + 1, 0, 0, L, 32'hDEADBEEF);
      run("ram top load", 1, 32'h9FFF_FFFC, 0, 4'hF, 0, L + 1, 32'h13, 0, L, 0);

      // 3. both ports requesting continuously from reset
      @(posedge clk); #1;
      rst_ni = 0;
      if_req = 1; if_addr = 32'h8000_0000;
      d_req = 1; d_addr = 32'h5000_0004; d_we = 0; d_be = 4'hF;
      repeat (2) @(posedge clk);
      #1 rst_ni = 1;
      cyc = 0;
      while (gq.size() < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (d_gnt)  begin gq.push_back(1); gcyc.push_back(cyc); end
         if (if_gnt) begin gq.push_back(0); gcyc.push_back(cyc); end
      end
      @(posedge clk); #1 if_req = 0; d_req = 0;
      chk("arb grants seen", gq.size(), 4);
      if (gq.size() == 4) begin
         chk("arb order", {gq[0][0], gq[1][0], gq[2][0], gq[3][0]}, 4'b1010);
         chk("arb first cycle", gcyc[0], 1);
         chk("arb gap mmio", gcyc[1] - gcyc[0], 3);
         chk("arb gap ram", gcyc[2] - gcyc[1], L + 2);
      end
      repeat (6) @(posedge clk);

      // 6. reset in the middle of a RAM access
      #1 d_req = 1; d_addr = 32'h8000_0000; d_we = 0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d_gnt) begin ok = 1; break; end
      end
      chk("rst gnt", ok, 1);
      @(posedge clk); #1 d_req = 0; rst_ni = 0;
      @(negedge clk);
      chk("rst access en", en_ram, 1);
      @(negedge clk);
      chk("rst outputs", {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, en_ram, en_leds, en_seg, en_btn, bus_we, bus_be}, 0);
      chk("rst bus", bus_addr | bus_wdata | d_rdata | if_rdata, 0);
      @(posedge clk); #1 rst_ni = 1; d_req = 1; d_addr = 32'h5000_0004;
      @(negedge clk);
      chk("post-rst gnt", d_gnt, 1);
      @(posedge clk); #1 d_req = 0;
      rv = 0;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (d_rvalid) begin rv++; n = i; end
      end
      chk("post-rst rvalid count", rv, 1);
      chk("post-rst rvalid cycle", n, 2);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
